// File: rtl/bfm_ahbl_slave_mem.sv
// AHB-Lite slave memory model: 2^AWIDTH x 32-bit words, optional fixed wait
// states on OKAY data phases, two-cycle ERROR for out-of-range/misaligned accesses.
module bfm_ahbl_slave_mem #(
  parameter int AWIDTH      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              dp_vld_q, dp_vld_d;
  logic [AWIDTH+1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       hrdata_q;
  logic [31:0]       mem [0:(1<<AWIDTH)-1];

  logic              open, acc, addr_err, cmp, wr_cmp, rd_cmp;
  logic [AWIDTH-1:0] idx;
  logic [3:0]        be;
  logic              unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // A new address phase can only land while this slave is presenting ready.
  assign open     = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign acc      = open & HSEL & HREADY & HTRANS[1];
  assign addr_err = (|HADDR[31:AWIDTH+2]) | (HSIZE > 3'd2) |
                    ((HSIZE == 3'd1) & HADDR[0]) |
                    ((HSIZE == 3'd2) & (|HADDR[1:0]));
  assign cmp      = dp_vld_q & (state_q == S_IDLE);
  assign wr_cmp   = cmp & write_q;
  assign rd_cmp   = cmp & ~write_q;
  assign idx      = addr_q[AWIDTH+1:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dp_vld_d = dp_vld_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    if (acc) begin
      addr_d  = HADDR[AWIDTH+1:0];
      write_d = HWRITE;
      size_d  = HSIZE[1:0];
    end
    case (state_q)
      S_IDLE, S_ERR2: begin
        dp_vld_d = acc & ~addr_err;
        state_d  = S_IDLE;
        if (acc && addr_err) begin
          state_d = S_ERR1;
        end else if (acc && (WAIT_STATES > 0)) begin
          state_d = S_WAIT;
          cnt_d   = WS_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_ERR2;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      dp_vld_q <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      hrdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dp_vld_q <= dp_vld_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      hrdata_q <= HRDATA;
    end
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'd0:    be[addr_q[1:0]] = 1'b1;
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Array is never reset; commits land on the edge that ends the data phase.
  always_ff @(posedge HCLK) begin
    if (wr_cmp) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign HRDATA    = rd_cmp ? mem[idx] : hrdata_q;

endmodule

// File: tb/tb_bfm_ahbl_slave_mem.sv
// Directed bench: instance 0 has no wait states, instance 1 has three; read
// data is checked against a reference memory through a scoreboard queue.
module tb_bfm_ahbl_slave_mem;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, sel, wr, rdy, resp;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [1:0]  trans [2];
  logic [2:0]  size [2];

  logic [31:0] mdl [2][1024];
  logic [31:0] sb [$];
  int n_cmp = 0;
  int n_err = 0;

  bfm_ahbl_slave_mem #(.AWIDTH(10), .WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(rst[0]), .HSEL(sel[0]), .HADDR(addr[0]), .HTRANS(trans[0]),
    .HWRITE(wr[0]), .HSIZE(size[0]), .HBURST(3'd0), .HPROT(4'h3), .HMASTLOCK(1'b0),
    .HWDATA(wdata[0]), .HREADY(rdy[0]), .HREADYOUT(rdy[0]), .HRESP(resp[0]),
    .HRDATA(rdata[0]));

  bfm_ahbl_slave_mem #(.AWIDTH(10), .WAIT_STATES(3)) u3 (
    .HCLK(clk), .HRESET(rst[1]), .HSEL(sel[1]), .HADDR(addr[1]), .HTRANS(trans[1]),
    .HWRITE(wr[1]), .HSIZE(size[1]), .HBURST(3'd0), .HPROT(4'h3), .HMASTLOCK(1'b0),
    .HWDATA(wdata[1]), .HREADY(rdy[1]), .HREADYOUT(rdy[1]), .HRESP(resp[1]),
    .HRDATA(rdata[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [2:0] sz, input logic [1:0] a);
    logic [31:0] r;
    r = old;
    case (sz)
      3'd0:    r[8*a +: 8] = wd[8*a +: 8];
      3'd1:    if (a[1]) r[31:16] = wd[31:16]; else r[15:0] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // One non-pipelined transfer: address phase, then data phase to completion.
  task automatic xfer(input int d, input bit w, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input bit exp_err, input int exp_w,
                      input string tag);
    int waits;
    bit done;
    logic [31:0] exp;
    waits = 0;
    done  = 1'b0;
    @(negedge clk);
    sel[d] = 1'b1; trans[d] = 2'b10; addr[d] = a; wr[d] = w; size[d] = sz;
    if (!w && !exp_err) sb.push_back(mdl[d][a[11:2]]);
    @(posedge clk); #1;
    sel[d] = 1'b0; trans[d] = 2'b00; wdata[d] = wd;
    if (exp_err) begin
      @(negedge clk);
      chk({tag, " err1"}, {30'd0, rdy[d], resp[d]}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk({tag, " err2"}, {30'd0, rdy[d], resp[d]}, 32'd3);
    end else begin
      for (int i = 0; i < 40 && !done; i++) begin
        @(negedge clk);
        if (rdy[d]) done = 1'b1;
        else begin
          waits++;
          @(posedge clk);
        end
      end
      chk({tag, " done"}, {31'd0, done}, 32'd1);
      chk({tag, " waits"}, waits, exp_w);
      chk({tag, " resp"}, {31'd0, resp[d]}, 32'd0);
      if (w) mdl[d][a[11:2]] = merge(mdl[d][a[11:2]], wd, sz, a[1:0]);
      else begin
        exp = sb.pop_front();
        chk({tag, " rdata"}, rdata[d], exp);
      end
    end
  endtask

  initial begin
    rst = 2'b11; sel = 2'b00; wr = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; wdata[i] = '0; trans[i] = 2'b00; size[i] = 3'd2;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset%0d", i), {rdy[i], resp[i], rdata[i][29:0]}, 32'h8000_0000);
    @(negedge clk);
    rst = 2'b00;

    // Back-to-back write then read of the same word at full rate.
    @(negedge clk);
    sel[0] = 1'b1; trans[0] = 2'b10; addr[0] = 32'h10; wr[0] = 1'b1; size[0] = 3'd2;
    @(posedge clk); #1;
    wr[0] = 1'b0; wdata[0] = 32'hDEAD_BEEF;
    sb.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    chk("b2b wr ready", {31'd0, rdy[0]}, 32'd1);
    @(posedge clk); #1;
    sel[0] = 1'b0; trans[0] = 2'b00;
    @(negedge clk);
    chk("b2b rd ready", {31'd0, rdy[0]}, 32'd1);
    chk("b2b rdata", rdata[0], sb.pop_front());
    mdl[0][4] = 32'hDEAD_BEEF;

    // Sub-word writes merge into the stored word.
    xfer(0, 1, 3'd2, 32'h10, 32'h1122_3344, 0, 0, "w word");
    xfer(0, 1, 3'd0, 32'h13, 32'hAA00_0000, 0, 0, "w byte");
    xfer(0, 0, 3'd2, 32'h10, 32'h0, 0, 0, "r byte");
    chk("byte merge lit", mdl[0][4], 32'hAA22_3344);
    @(negedge clk);
    chk("rdata hold", rdata[0], 32'hAA22_3344);
    xfer(0, 1, 3'd1, 32'h12, 32'hBEEF_0000, 0, 0, "w half");
    xfer(0, 0, 3'd2, 32'h10, 32'h0, 0, 0, "r half");

    // Error responses and recovery.
    xfer(0, 1, 3'd2, 32'h4, 32'hCAFE_F00D, 0, 0, "w 0x4");
    xfer(0, 0, 3'd2, 32'h2, 32'h0, 1, 0, "r unaligned");
    xfer(0, 0, 3'd2, 32'h4, 32'h0, 0, 0, "r 0x4");
    xfer(0, 1, 3'd1, 32'h11, 32'h1234_5678, 1, 0, "half odd");
    xfer(0, 1, 3'd3, 32'h8, 32'h1234_5678, 1, 0, "size3");
    xfer(0, 1, 3'd2, 32'h0, 32'h0BAD_F00D, 0, 0, "w 0x0");
    xfer(0, 1, 3'd2, 32'h1000, 32'h1234_5678, 1, 0, "w range");
    xfer(0, 0, 3'd2, 32'h0, 32'h0, 0, 0, "r 0x0");
    xfer(0, 0, 3'd1, 32'h12, 32'h0, 0, 0, "r 0x12 half");

    // Wait-state instance.
    xfer(1, 1, 3'd2, 32'h40, 32'h5566_7788, 0, 3, "ws w");
    xfer(1, 0, 3'd2, 32'h40, 32'h0, 0, 3, "ws r");
    xfer(1, 0, 3'd2, 32'h41, 32'h0, 1, 0, "ws err");

    // Reset in the second wait cycle of a write.
    @(negedge clk);
    sel[1] = 1'b1; trans[1] = 2'b10; addr[1] = 32'h40; wr[1] = 1'b1; size[1] = 3'd2;
    @(posedge clk); #1;
    sel[1] = 1'b0; trans[1] = 2'b00; wdata[1] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    #1;
    chk("mid rst outs", {rdy[1], resp[1], rdata[1][29:0]}, 32'h8000_0000);
    chk("mid rst rdata", rdata[1], 32'h0);
    @(negedge clk);
    rst[1] = 1'b0;
    xfer(1, 0, 3'd2, 32'h40, 32'h0, 0, 3, "post rst r");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
